// File: rtl/wshb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin fairness.
// Define ARB_QUOTA_EN to make the owner yield after MAX_ACKS transfers when the other master waits.
module wshb_arbiter #(
    parameter int unsigned MAX_ACKS = 16,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW/8-1:0] m0_sel,
    input  logic [DW-1:0]   m0_dat_ms,
    output logic            m0_ack,
    output logic [DW-1:0]   m0_dat_sm,

    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW/8-1:0] m1_sel,
    input  logic [DW-1:0]   m1_dat_ms,
    output logic            m1_ack,
    output logic [DW-1:0]   m1_dat_sm,

    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW/8-1:0] s_sel,
    output logic [DW-1:0]   s_dat_ms,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_dat_sm,

    output logic [1:0]      gnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

    state_e r_state;
    state_e w_state_nxt;
    logic   r_last;
    logic   w_last_nxt;

    // Owner-relative views so the release/quota rules are written once.
    logic   w_owner;
    logic   w_own_cyc;
    logic   w_own_stb;
    logic   w_oth_cyc;
    state_e w_oth_state;

    assign w_owner     = (r_state == StOwn1);
    assign w_own_cyc   = w_owner ? m1_cyc : m0_cyc;
    assign w_own_stb   = w_owner ? m1_stb : m0_stb;
    assign w_oth_cyc   = w_owner ? m0_cyc : m1_cyc;
    assign w_oth_state = w_owner ? StOwn0 : StOwn1;

`ifdef ARB_QUOTA_EN
    localparam int unsigned CW = $clog2(MAX_ACKS + 1);
    localparam logic [CW-1:0] CntMax   = CW'(MAX_ACKS);
    localparam logic [CW-1:0] CntMaxM1 = CW'(MAX_ACKS - 1);

    logic [CW-1:0] r_ack_cnt;
    logic [CW-1:0] w_ack_cnt_nxt;
    logic          w_exhausted;

    // The ack landing this cycle counts toward the quota, so the switch follows the last allowed ack.
    assign w_exhausted = (r_ack_cnt == CntMax) || (s_ack && (r_ack_cnt == CntMaxM1));
`else
    logic w_unused_max_acks;
    assign w_unused_max_acks = (MAX_ACKS != 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
`ifdef ARB_QUOTA_EN
        w_ack_cnt_nxt = r_ack_cnt;
`endif
        unique case (r_state)
            StIdle: begin
                if (m0_cyc && m1_cyc) begin
                    w_state_nxt = r_last ? StOwn0 : StOwn1;
                end else if (m0_cyc) begin
                    w_state_nxt = StOwn0;
                end else if (m1_cyc) begin
                    w_state_nxt = StOwn1;
                end
            end
            StOwn0, StOwn1: begin
                if (!w_own_cyc) begin
                    w_state_nxt = w_oth_cyc ? w_oth_state : StIdle;
                    w_last_nxt  = w_owner;
`ifdef ARB_QUOTA_EN
                    w_ack_cnt_nxt = '0;
                end else if (w_exhausted && w_oth_cyc && (s_ack || !w_own_stb)) begin
                    w_state_nxt   = w_oth_state;
                    w_last_nxt    = w_owner;
                    w_ack_cnt_nxt = '0;
                end else if (s_ack && (r_ack_cnt != CntMax)) begin
                    w_ack_cnt_nxt = r_ack_cnt + 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

`ifndef ARB_QUOTA_EN
    logic w_unused_own_stb;
    assign w_unused_own_stb = w_own_stb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

`ifdef ARB_QUOTA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_cnt <= '0;
        end else begin
            r_ack_cnt <= w_ack_cnt_nxt;
        end
    end
`endif

    // Pure mux on registered state: reset forces StIdle, which drops every output at once.
    always_comb begin
        s_cyc     = 1'b0;
        s_stb     = 1'b0;
        s_we      = 1'b0;
        s_adr     = '0;
        s_sel     = '0;
        s_dat_ms  = '0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        m0_dat_sm = '0;
        m1_dat_sm = '0;
        gnt       = 2'b00;
        unique case (r_state)
            StOwn0: begin
                s_cyc     = m0_cyc;
                s_stb     = m0_stb;
                s_we      = m0_we;
                s_adr     = m0_adr;
                s_sel     = m0_sel;
                s_dat_ms  = m0_dat_ms;
                m0_ack    = s_ack;
                m0_dat_sm = s_dat_sm;
                m1_dat_sm = s_dat_sm;
                gnt       = 2'b01;
            end
            StOwn1: begin
                s_cyc     = m1_cyc;
                s_stb     = m1_stb;
                s_we      = m1_we;
                s_adr     = m1_adr;
                s_sel     = m1_sel;
                s_dat_ms  = m1_dat_ms;
                m1_ack    = s_ack;
                m0_dat_sm = s_dat_sm;
                m1_dat_sm = s_dat_sm;
                gnt       = 2'b10;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed self-checking bench for wshb_arbiter; expectations follow ARB_QUOTA_EN if defined.
module tb_wshb_arbiter;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned MAX_ACKS = 4;

    logic            clk;
    logic            rst_n;
    logic            m0_cyc, m0_stb, m0_we;
    logic [AW-1:0]   m0_adr;
    logic [DW/8-1:0] m0_sel;
    logic [DW-1:0]   m0_dat_ms;
    logic            m0_ack;
    logic [DW-1:0]   m0_dat_sm;
    logic            m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]   m1_adr;
    logic [DW/8-1:0] m1_sel;
    logic [DW-1:0]   m1_dat_ms;
    logic            m1_ack;
    logic [DW-1:0]   m1_dat_sm;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW/8-1:0] s_sel;
    logic [DW-1:0]   s_dat_ms;
    logic            s_ack;
    logic [DW-1:0]   s_dat_sm;
    logic [1:0]      gnt;

    int n_checks = 0;
    int n_fail   = 0;

    wshb_arbiter #(
        .MAX_ACKS (MAX_ACKS),
        .AW       (AW),
        .DW       (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_cyc    (m0_cyc),
        .m0_stb    (m0_stb),
        .m0_we     (m0_we),
        .m0_adr    (m0_adr),
        .m0_sel    (m0_sel),
        .m0_dat_ms (m0_dat_ms),
        .m0_ack    (m0_ack),
        .m0_dat_sm (m0_dat_sm),
        .m1_cyc    (m1_cyc),
        .m1_stb    (m1_stb),
        .m1_we     (m1_we),
        .m1_adr    (m1_adr),
        .m1_sel    (m1_sel),
        .m1_dat_ms (m1_dat_ms),
        .m1_ack    (m1_ack),
        .m1_dat_sm (m1_dat_sm),
        .s_cyc     (s_cyc),
        .s_stb     (s_stb),
        .s_we      (s_we),
        .s_adr     (s_adr),
        .s_sel     (s_sel),
        .s_dat_ms  (s_dat_ms),
        .s_ack     (s_ack),
        .s_dat_sm  (s_dat_sm),
        .gnt       (gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        m0_cyc = 1'b0;
        m0_stb = 1'b0;
        m1_cyc = 1'b0;
        m1_stb = 1'b0;
        s_ack  = 1'b0;
    endtask

    task automatic raise_both();
        m0_cyc = 1'b1;
        m0_stb = 1'b1;
        m1_cyc = 1'b1;
        m1_stb = 1'b1;
    endtask

    logic [1:0] exp_gnt;
    bit         quota;

    initial begin
`ifdef ARB_QUOTA_EN
        quota = 1'b1;
`else
        quota = 1'b0;
`endif
        rst_n     = 1'b0;
        raise_both();
        s_ack     = 1'b0;
        m0_we     = 1'b0;
        m0_adr    = 32'h10;
        m0_sel    = 4'hF;
        m0_dat_ms = 32'h0;
        m1_we     = 1'b1;
        m1_adr    = 32'h20;
        m1_sel    = 4'h3;
        m1_dat_ms = 32'hCAFEBABE;
        s_dat_sm  = 32'h12345678;

        #2;
        check_eq("rst_gnt", 64'(gnt), 64'h0);
        check_eq("rst_s_cyc", 64'(s_cyc), 64'h0);

        // Reset release with both requesting: master 0 wins the first tie.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("lat_idle_gnt", 64'(gnt), 64'h0);
        tick();
        check_eq("first_gnt", 64'(gnt), 64'h1);
        check_eq("m0_s_adr", 64'(s_adr), 64'h10);
        check_eq("m0_s_we", 64'(s_we), 64'h0);
        check_eq("m0_s_stb", 64'(s_stb), 64'h1);
        s_ack = 1'b1;
        #1;
        check_eq("m0_ack", 64'(m0_ack), 64'h1);
        check_eq("m0_dat_sm", 64'(m0_dat_sm), 64'h12345678);
        check_eq("m1_ack_wait", 64'(m1_ack), 64'h0);

        // m0 releases while m1 waits: handover one clock later with no idle cycle.
        tick();
        s_ack  = 1'b0;
        m0_cyc = 1'b0;
        m0_stb = 1'b0;
        #1;
        check_eq("rel_gnt_hold", 64'(gnt), 64'h1);
        check_eq("rel_s_cyc", 64'(s_cyc), 64'h0);
        tick();
        check_eq("hand_gnt", 64'(gnt), 64'h2);
        check_eq("m1_s_adr", 64'(s_adr), 64'h20);
        check_eq("m1_s_we", 64'(s_we), 64'h1);
        check_eq("m1_s_dat", 64'(s_dat_ms), 64'hCAFEBABE);
        check_eq("m1_s_sel", 64'(s_sel), 64'h3);
        s_ack = 1'b1;
        #1;
        check_eq("m1_ack", 64'(m1_ack), 64'h1);
        check_eq("m0_ack_nonown", 64'(m0_ack), 64'h0);
        tick();
        drop_all();

        // Idle, last=1; a stray slave ack must not reach anyone.
        tick();
        check_eq("idle_gnt", 64'(gnt), 64'h0);
        s_ack = 1'b1;
        #1;
        check_eq("idle_m0_ack", 64'(m0_ack), 64'h0);
        check_eq("idle_m1_ack", 64'(m1_ack), 64'h0);
        s_ack = 1'b0;

        // Round-robin alternation with both masters requesting.
        raise_both();
        tick();
        exp_gnt = 2'b01;
        check_eq("tie_last1", 64'(gnt), 64'(exp_gnt));
        for (int i = 0; i < 4; i++) begin
            if (exp_gnt == 2'b01) begin
                m0_cyc = 1'b0;
                m0_stb = 1'b0;
            end else begin
                m1_cyc = 1'b0;
                m1_stb = 1'b0;
            end
            tick();
            raise_both();
            exp_gnt = {exp_gnt[0], exp_gnt[1]};
            #1;
            check_eq($sformatf("alt_%0d", i), 64'(gnt), 64'(exp_gnt));
        end
        drop_all();
        tick();
        check_eq("idle2_gnt", 64'(gnt), 64'h0);
        raise_both();
        tick();
        check_eq("tie_last0", 64'(gnt), 64'h2);
        drop_all();
        tick();

        // Continuous m0 with m1 waiting, ack every second clock.
        raise_both();
        tick();
        check_eq("q_start_gnt", 64'(gnt), 64'h1);
        for (int k = 0; k < 4; k++) begin
            s_ack = 1'b0;
            tick();
            s_ack = 1'b1;
            #1;
            check_eq($sformatf("q_ack_%0d", k), 64'(m0_ack), 64'h1);
            check_eq($sformatf("q_gnt_%0d", k), 64'(gnt), 64'h1);
            tick();
        end
        s_ack = 1'b0;
        #1;
        check_eq("q_after4_gnt", 64'(gnt), quota ? 64'h2 : 64'h1);
        s_ack = 1'b1;
        #1;
        check_eq("q_after4_m0ack", 64'(m0_ack), quota ? 64'h0 : 64'h1);
        check_eq("q_after4_m1ack", 64'(m1_ack), quota ? 64'h1 : 64'h0);
        tick();
        drop_all();
        tick();

        // m0 alone exceeds the quota, then m1 requests.
        m0_cyc = 1'b1;
        m0_stb = 1'b1;
        tick();
        s_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq($sformatf("solo_ack_%0d", k), 64'(m0_ack), 64'h1);
            tick();
            check_eq($sformatf("solo_gnt_%0d", k), 64'(gnt), 64'h1);
        end
        s_ack = 1'b0;
`ifdef ARB_QUOTA_EN
        #1;
        check_eq("solo_cnt_sat", 64'(dut.r_ack_cnt), 64'(MAX_ACKS));
`endif
        m1_cyc = 1'b1;
        m1_stb = 1'b1;
        tick();
        check_eq("solo_wait_gnt", 64'(gnt), 64'h1);
        s_ack = 1'b1;
        #1;
        check_eq("solo_last_ack", 64'(m0_ack), 64'h1);
        tick();
        s_ack = 1'b0;
        #1;
        check_eq("solo_switch", 64'(gnt), quota ? 64'h2 : 64'h1);
        m0_cyc = 1'b0;
        m0_stb = 1'b0;
        tick();
        check_eq("solo_release", 64'(gnt), 64'h2);

        // Asynchronous reset in the middle of an m1 transfer.
        check_eq("pre_rst_s_stb", 64'(s_stb), 64'h1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        s_ack = 1'b1;
        #1;
        check_eq("arst_s_cyc", 64'(s_cyc), 64'h0);
        check_eq("arst_s_stb", 64'(s_stb), 64'h0);
        check_eq("arst_s_we", 64'(s_we), 64'h0);
        check_eq("arst_gnt", 64'(gnt), 64'h0);
        check_eq("arst_m0_ack", 64'(m0_ack), 64'h0);
        check_eq("arst_m1_ack", 64'(m1_ack), 64'h0);
        drop_all();
        #10;
        rst_n = 1'b1;
        #10;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
